// File: rtl/read_stage_request_sequencer.sv
// read_stage_request_sequencer
// Expands one VRF read command into a stream of per-element read requests
// for the read-stage arbiter. An 9-bit element counter walks 0..count-1; the
// low nibble is the offset inside a vector register and the next nibble is
// the register group, which also advances the vector register number.
// A matching kill aborts the command; a FINISH state covers count == 0.

module read_stage_request_sequencer #(
  parameter int MAX_COUNT      = 256,
  parameter int OFFSETS_PER_VS = 16
) (
  input  logic       clock,
  input  logic       reset,

  output logic       cmd_ready,
  input  logic       cmd_valid,
  input  logic [4:0] cmd_bits_vs,
  input  logic [8:0] cmd_bits_count,
  input  logic [3:0] cmd_bits_readSource,
  input  logic [2:0] cmd_bits_instructionIndex,

  input  logic       kill_valid,
  input  logic [2:0] kill_instructionIndex,

  input  logic       out_ready,
  output logic       out_valid,
  output logic [4:0] out_bits_vs,
  output logic [3:0] out_bits_offset,
  output logic [3:0] out_bits_groupIndex,
  output logic [3:0] out_bits_readSource,
  output logic [2:0] out_bits_instructionIndex,

  output logic       done,
  output logic       aborted
);

  // Counter must hold MAX_COUNT itself (count is 0..MAX_COUNT inclusive).
  localparam int CntW = $clog2(MAX_COUNT) + 1;
  localparam int OffW = $clog2(OFFSETS_PER_VS);
  localparam int GrpW = CntW - 1 - OffW;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_nextState;

  logic [4:0]        r_vs;
  logic [CntW-1:0]   r_count;
  logic [3:0]        r_readSource;
  logic [2:0]        r_instructionIndex;
  logic [CntW-1:0]   r_n;
  logic              r_done;
  logic              r_aborted;

  logic              w_loadCmd;
  logic              w_advance;
  logic              w_setDone;
  logic              w_setAbort;
  logic              w_killHit;
  logic              w_lastElem;
  logic [GrpW-1:0]   w_group;
  logic [OffW-1:0]   w_offset;

  // A kill only matters when it names the instruction we are working for.
  assign w_killHit  = kill_valid && (kill_instructionIndex == r_instructionIndex);
  assign w_lastElem = (r_n == (r_count - CntW'(1)));
  assign w_offset   = r_n[OffW-1:0];
  assign w_group    = r_n[OffW+GrpW-1:OffW];

  // Next-state and control decode; kill takes priority over a handshake.
  always_comb begin
    w_nextState = r_state;
    w_loadCmd   = 1'b0;
    w_advance   = 1'b0;
    w_setDone   = 1'b0;
    w_setAbort  = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_loadCmd   = 1'b1;
          w_nextState = (cmd_bits_count == '0) ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        if (w_killHit) begin
          w_setAbort  = 1'b1;
          w_nextState = IDLE;
        end else if (out_ready) begin
          if (w_lastElem) begin
            w_setDone   = 1'b1;
            w_nextState = IDLE;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      FINISH: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Command latch and element counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_vs               <= '0;
      r_count            <= '0;
      r_readSource       <= '0;
      r_instructionIndex <= '0;
      r_n                <= '0;
    end else if (w_loadCmd) begin
      r_vs               <= cmd_bits_vs;
      r_count            <= cmd_bits_count;
      r_readSource       <= cmd_bits_readSource;
      r_instructionIndex <= cmd_bits_instructionIndex;
      r_n                <= '0;
    end else if (w_advance) begin
      r_n <= r_n + CntW'(1);
    end
  end

  // One-cycle completion pulses for commands that ran through ISSUE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_done    <= w_setDone;
      r_aborted <= w_setAbort;
    end
  end

  // Output decode. FINISH reports its own pulse in-cycle so that a matching
  // kill seen while sitting in FINISH turns the done into an aborted.
  always_comb begin
    cmd_ready                 = (r_state == IDLE);
    out_valid                 = (r_state == ISSUE);
    out_bits_offset           = w_offset;
    out_bits_groupIndex       = w_group;
    out_bits_vs               = r_vs + 5'(w_group);
    out_bits_readSource       = r_readSource;
    out_bits_instructionIndex = r_instructionIndex;
    done                      = r_done    || ((r_state == FINISH) && !w_killHit);
    aborted                   = r_aborted || ((r_state == FINISH) &&  w_killHit);
  end

endmodule
